// File: rtl/lut_seq_pkg.sv
// lut_seq_pkg: LUT geometry, sequencer states and the fan-in gather helper
package lut_seq_pkg;
  localparam int IN_BITS = 64;
  localparam int FANIN = 6;
  localparam int IDXW = 6;
  localparam int TT_W = 2 ** FANIN;
  localparam int IDX_LW = FANIN * IDXW;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  function automatic logic [FANIN-1:0] gather(input logic [IN_BITS-1:0] vec, input logic [IDX_LW-1:0] idx);
    logic [FANIN-1:0] a;
    logic [IDXW-1:0] k;
    a = '0;
    for (int j = 0; j < FANIN; j++) begin
      k = idx[j*IDXW +: IDXW];
      a[j] = (int'(k) < IN_BITS) ? vec[k] : 1'b0;
    end
    return a;
  endfunction
endpackage

// File: rtl/lut_layer_sequencer_ram.sv
// lut_layer_sequencer_ram: per-neuron truth table and index list, separate write enables, registered read
module lut_layer_sequencer_ram import lut_seq_pkg::*; #(
  parameter int DEPTH = 128,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              tt_we,
  input  logic              idx_we,
  input  logic [AW-1:0]     waddr,
  input  logic [TT_W-1:0]   tt_wdata,
  input  logic [IDX_LW-1:0] idx_wdata,
  input  logic [AW-1:0]     raddr,
  output logic [TT_W-1:0]   tt_rdata,
  output logic [IDX_LW-1:0] idx_rdata
);
  logic [TT_W-1:0] tt_mem [DEPTH];
  logic [IDX_LW-1:0] idx_mem [DEPTH];
  always_ff @(posedge clk) begin
    if (tt_we) tt_mem[waddr] <= tt_wdata;
    if (idx_we) idx_mem[waddr] <= idx_wdata;
    tt_rdata <= tt_mem[raddr];
    idx_rdata <= idx_mem[raddr];
  end
endmodule

// File: rtl/lut_layer_sequencer.sv
// lut_layer_sequencer: evaluates one LUT neuron per cycle across a whole layer
// and returns the packed layer output vector.
module lut_layer_sequencer import lut_seq_pkg::*; #(
  parameter int NUM_NEURONS = 128
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           cfg_tt_we,
  input  logic                           cfg_idx_we,
  input  logic [$clog2(NUM_NEURONS)-1:0] cfg_neuron,
  input  logic [TT_W-1:0]                cfg_tt_data,
  input  logic [IDX_LW-1:0]              cfg_idx_data,
  output logic                           cfg_ready,
  output logic                           cfg_err,
  input  logic                           in_valid,
  input  logic [IN_BITS-1:0]             in_data,
  output logic                           in_ready,
  output logic                           out_valid,
  output logic [NUM_NEURONS-1:0]         out_data,
  input  logic                           out_ready
);
  localparam int NW = $clog2(NUM_NEURONS);
  localparam logic [NW-1:0] LAST = NW'(NUM_NEURONS - 1);
  state_t state, state_nx;
  logic [NW-1:0] cnt, rd_n;
  logic rd_v, cfg_req, cfg_ok;
  logic [IN_BITS-1:0] vec;
  logic [TT_W-1:0] tt_q;
  logic [IDX_LW-1:0] idx_q;
  assign in_ready = state == IDLE;
  assign cfg_ready = state == IDLE;
  assign out_valid = state == DONE;
  assign cfg_req = cfg_tt_we | cfg_idx_we;
  assign cfg_ok = cfg_ready & ~(cfg_tt_we & cfg_idx_we) & (int'({1'b0, cfg_neuron}) < NUM_NEURONS);
  lut_layer_sequencer_ram #(.DEPTH(NUM_NEURONS)) u_ram (
    .clk(clk),
    .tt_we(cfg_tt_we & cfg_ok),
    .idx_we(cfg_idx_we & cfg_ok),
    .waddr(cfg_neuron),
    .tt_wdata(cfg_tt_data),
    .idx_wdata(cfg_idx_data),
    .raddr(cnt),
    .tt_rdata(tt_q),
    .idx_rdata(idx_q)
  );
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: state_nx = in_valid ? RUN : IDLE;
      RUN: state_nx = (cnt == LAST) ? DRAIN : RUN;
      DRAIN: state_nx = DONE;
      DONE: state_nx = out_ready ? IDLE : DONE;
    endcase
  end
  // The index list and truth table arrive together, so the gather happens on the read-return cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      rd_n <= '0;
      rd_v <= 1'b0;
      vec <= '0;
      out_data <= '0;
      cfg_err <= 1'b0;
    end else begin
      state <= state_nx;
      cfg_err <= cfg_req & ~cfg_ok;
      rd_v <= state == RUN;
      rd_n <= cnt;
      if (state == IDLE && in_valid) begin
        vec <= in_data;
        cnt <= '0;
        out_data <= '0;
      end else if (state == RUN && cnt != LAST) cnt <= cnt + 1'b1;
      if (rd_v) out_data[rd_n] <= tt_q[gather(vec, idx_q)];
    end
  end
endmodule

// File: tb/tb_lut_layer_sequencer.sv
// tb_lut_layer_sequencer: directed and random checks of the layer sequencer against
// a cycle-age reference model plus hand-computed literals.
module tb_lut_layer_sequencer;
  localparam int NN = 4;
  localparam int LAT = NN + 2;
  logic clk = 0, rst_n = 0;
  logic cfg_tt_we = 0, cfg_idx_we = 0;
  logic [1:0] cfg_neuron = '0;
  logic [63:0] cfg_tt_data = '0;
  logic [35:0] cfg_idx_data = '0;
  logic cfg_ready, cfg_err, in_ready, out_valid;
  logic in_valid = 0, out_ready = 0;
  logic [63:0] in_data = '0;
  logic [NN-1:0] out_data;
  int checks = 0, errors = 0, cyc = 0;
  logic [63:0] m_tt [NN];
  int m_idx [NN][6];
  bit m_busy = 0, m_err = 0;
  int m_age = 0;
  logic [NN-1:0] m_res = '0;

  lut_layer_sequencer #(.NUM_NEURONS(NN)) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_tt_we(cfg_tt_we), .cfg_idx_we(cfg_idx_we), .cfg_neuron(cfg_neuron),
    .cfg_tt_data(cfg_tt_data), .cfg_idx_data(cfg_idx_data),
    .cfg_ready(cfg_ready), .cfg_err(cfg_err),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [NN-1:0] model_eval(input logic [63:0] v);
    logic [NN-1:0] r;
    for (int n = 0; n < NN; n++) begin
      int a = 0;
      for (int j = 0; j < 6; j++)
        if (m_idx[n][j] < 64 && v[m_idx[n][j]]) a += 1 << j;
      r[n] = m_tt[n][a];
    end
    return r;
  endfunction

  // Reference: tables update only while idle; a result appears LAT edges after its accept
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy = 0;
      m_age = 0;
      m_err = 0;
    end else begin
      m_err = (cfg_tt_we || cfg_idx_we) && (m_busy || (cfg_tt_we && cfg_idx_we));
      if (!m_busy) begin
        if (cfg_tt_we && !cfg_idx_we) m_tt[cfg_neuron] = cfg_tt_data;
        if (cfg_idx_we && !cfg_tt_we)
          for (int j = 0; j < 6; j++) m_idx[cfg_neuron][j] = int'(cfg_idx_data[j*6 +: 6]);
        if (in_valid) begin
          m_busy = 1;
          m_age = 1;
          m_res = model_eval(in_data);
        end
      end else if (m_age == LAT) begin
        if (out_ready) m_busy = 0;
      end else m_age++;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("in_ready", in_ready, !m_busy);
      chk("cfg_ready", cfg_ready, !m_busy);
      chk("out_valid", out_valid, m_busy && m_age == LAT);
      chk("cfg_err", cfg_err, m_err);
      if (m_busy && m_age == LAT) chk("out_data", out_data, m_res);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [35:0] idx_word(input int s0);
    logic [35:0] w;
    for (int j = 0; j < 6; j++) w[j*6 +: 6] = 6'((j == 0) ? s0 : j);
    return w;
  endfunction

  task automatic set_cfg(input logic tw, input logic iw, input int n, input logic [63:0] tt, input logic [35:0] iv);
    cfg_tt_we = tw;
    cfg_idx_we = iw;
    cfg_neuron = 2'(n);
    cfg_tt_data = tt;
    cfg_idx_data = iv;
    tick();
    cfg_tt_we = 0;
    cfg_idx_we = 0;
  endtask

  task automatic start(input logic [63:0] v);
    in_valid = 1;
    in_data = v;
    tick();
    in_valid = 0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 1;
    while (!out_valid && lat < 50) begin
      tick();
      lat++;
    end
    if (!out_valid) chk("timeout out_valid", 0, 1);
  endtask

  task automatic release_out();
    out_ready = 1;
    tick();
    out_ready = 0;
  endtask

  task automatic run_vec(input logic [63:0] v, output logic [NN-1:0] res, output int lat);
    start(v);
    wait_valid(lat);
    res = out_data;
    release_out();
  endtask

  initial begin
    logic [NN-1:0] res;
    int lat, prev, k;
    logic [35:0] w;
    #2;
    chk("rst in_ready", in_ready, 1);
    chk("rst cfg_ready", cfg_ready, 1);
    chk("rst out_valid", out_valid, 0);
    chk("rst out_data", out_data, 0);
    chk("rst cfg_err", cfg_err, 0);
    #10 rst_n = 1;
    tick();
    // one-hot tables on a direct 6-bit address
    for (int n = 0; n < NN; n++) begin
      set_cfg(1, 0, n, 64'h1 << n, '0);
      set_cfg(0, 1, n, '0, idx_word(0));
    end
    chk("model pin t1", model_eval(64'h2), 4'b0100);
    run_vec(64'h2, res, lat);
    chk("t1 data", res, 4'b0100);
    chk("t1 latency", lat, 6);
    run_vec(64'h3, res, lat);
    chk("t1 data 3", res, 4'b1000);
    // both enables together are rejected in IDLE
    set_cfg(1, 1, 0, '1, idx_word(0));
    chk("both we err", cfg_err, 1);
    run_vec(64'h2, res, lat);
    chk("both we unchanged", res, 4'b0100);
    // hold the result while a new vector is offered
    start(64'h2);
    wait_valid(lat);
    in_valid = 1;
    in_data = 64'h1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("t3 hold data", out_data, 4'b0100);
      chk("t3 in_ready", in_ready, 0);
    end
    in_valid = 0;
    release_out();
    chk("t3 idle in_ready", in_ready, 1);
    tick();
    tick();
    chk("t3 not captured", out_valid, 0);
    // table write during RUN is refused
    start(64'h3);
    tick();
    cfg_tt_we = 1;
    cfg_neuron = 0;
    cfg_tt_data = '1;
    tick();
    cfg_tt_we = 0;
    chk("t4 err pulse", cfg_err, 1);
    tick();
    chk("t4 err clear", cfg_err, 0);
    wait_valid(lat);
    chk("t4 data", out_data, 4'b1000);
    release_out();
    run_vec(64'h1, res, lat);
    chk("t4 old table", res, 4'b0010);
    // reset in the second RUN cycle aborts the vector
    start(64'h2);
    tick();
    rst_n = 0;
    #1;
    chk("t5 out_valid", out_valid, 0);
    chk("t5 in_ready", in_ready, 1);
    #2 rst_n = 1;
    tick();
    tick();
    chk("t5 no result", out_valid, 0);
    run_vec(64'h2, res, lat);
    chk("t5 recover", res, 4'b0100);
    // output follows input bit 7
    for (int n = 0; n < NN; n++) begin
      set_cfg(1, 0, n, 64'hAAAA_AAAA_AAAA_AAAA, '0);
      set_cfg(0, 1, n, '0, idx_word(7));
    end
    chk("model pin t2", model_eval(64'h80), 4'b1111);
    run_vec(64'h80, res, lat);
    chk("t2 ones", res, 4'b1111);
    run_vec(64'h0, res, lat);
    chk("t2 zeros", res, 4'b0000);
    run_vec(64'h7F, res, lat);
    chk("t2 bit7 low", res, 4'b0000);
    // random tables, back-to-back vectors
    for (int r = 0; r < 100; r++) begin
      for (int n = 0; n < NN; n++) begin
        set_cfg(1, 0, n, {$urandom, $urandom}, '0);
        for (int j = 0; j < 6; j++) w[j*6 +: 6] = 6'($urandom_range(0, 63));
        set_cfg(0, 1, n, '0, w);
      end
      out_ready = 1;
      prev = -1;
      for (int v = 0; v < 10; v++) begin
        in_data = {$urandom, $urandom};
        in_valid = 1;
        k = 0;
        while (!in_ready && k < 50) begin
          tick();
          k++;
        end
        if (!in_ready) chk("timeout in_ready", 0, 1);
        tick();
        if (prev >= 0) chk("spacing", cyc - prev, NN + 3);
        prev = cyc;
      end
      in_valid = 0;
      k = 0;
      while (!in_ready && k < 50) begin
        tick();
        k++;
      end
      if (!in_ready) chk("timeout drain", 0, 1);
      out_ready = 0;
    end
    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
endmodule
